// File: rtl/event_enc_pkg.sv
// Shared constants and helpers for the 16-to-4 event encoder.
package event_enc_pkg;

  localparam int N_REQ  = 16;
  localparam int CODE_W = 4;

  function automatic logic [15:0] onehot16(input logic [3:0] c);
    return 16'(1) << c;
  endfunction

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + 5'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/event_encoder_16to4_prio_pick.sv
// Combinational picker: first set bit of avail searching upward from start, wrapping.
module prio_pick (
  input  logic [15:0] avail,
  input  logic [3:0]  start,
  output logic [3:0]  idx,
  output logic        any
);
  import event_enc_pkg::*;

  logic [3:0] j;

  always_comb begin
    idx = '0;
    any = 1'b0;
    j   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      j = start + 4'(i);
      if (avail[j] && !any) begin
        idx = j;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/event_encoder_16to4.sv
// Captures 16 event pulses into a pending set and serializes them as 4-bit codes.
// Define EVENT_ENCODER_ROUND_ROBIN_EN for rotating priority; default is lowest-index-first.
module event_encoder_16to4 #(
  parameter int N_REQ  = 16,
  parameter int CODE_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req,
  input  logic              ready,
  output logic              valid,
  output logic [CODE_W-1:0] code,
  output logic [CODE_W:0]   pending_cnt,
  output logic              drop
);
  import event_enc_pkg::*;

  logic [N_REQ-1:0]  pending;
  logic [N_REQ-1:0]  clr, avail, pend_nxt;
  logic              accept, load, any;
  logic [CODE_W-1:0] idx, start;

  assign accept   = valid & ready;
  assign clr      = accept ? onehot16(code) : '0;
  // set wins over clear so a re-fired event is re-queued
  assign pend_nxt = (pending & ~clr) | req;
  assign avail    = pending & ~clr;
  assign load     = !valid || accept;

`ifdef EVENT_ENCODER_ROUND_ROBIN_EN
  logic [CODE_W-1:0] last;

  assign start = last + 4'd1;

  always_ff @(posedge clk) begin
    if (rst)         last <= 4'hF;
    else if (accept) last <= code;
  end
`else
  assign start = '0;
`endif

  prio_pick u_pick (
    .avail (avail),
    .start (start),
    .idx   (idx),
    .any   (any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pending     <= '0;
      valid       <= 1'b0;
      code        <= '0;
      pending_cnt <= '0;
      drop        <= 1'b0;
    end else begin
      pending     <= pend_nxt;
      pending_cnt <= popcount16(pend_nxt);
      if (|(req & pending & ~clr)) drop <= 1'b1;
      // code only moves when the consumer is not stalled on it
      if (load) begin
        valid <= any;
        if (any) code <= idx;
      end
    end
  end

endmodule
